// File: rtl/decade_timer_pkg.sv
// Shared types and constants for the decimal event timer.
// Imported by the digit cell and the controller.
package decade_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/decade_timer_ctrl_bcd_digit.sv
// One BCD decade: synchronous clear, enable-gated increment 0..9.
// tc flags the terminal value so the controller can ripple the carry.
module bcd_digit
  import decade_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               tc
);

  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign tc = (q_q == BCD_MAX);

endmodule

// File: rtl/decade_timer_ctrl.sv
// Programmable decimal event timer: carry-chain enables, run/pause
// state machine and live-target compare over a chain of BCD digits.
module decade_timer_ctrl
  import decade_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic [DIGIT_W*DIGITS-1:0] target,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      running,
  output logic                      done,
  output logic                      wrap
);

  state_e state_q, state_d;

  logic [DIGITS-1:0]         tc;
  logic [DIGIT_W*DIGITS-1:0] cnt_nxt;
  logic                      carry;
  logic                      match, roll, tz;
  logic                      start_ok, clr_cnt;
  logic                      done_d, done_q;
  logic                      wrap_d, wrap_q;
  logic                      running_q;

  // Ripple enable: digit i steps only when every lower digit is at 9.
  always_comb begin
    digit_en = '0;
    carry    = tick & (state_q == ST_RUN)
             & ~stop & ~clear & ~rst;
    for (int i = 0; i < DIGITS; i++) begin
      digit_en[i] = carry;
      carry       = carry & tc[i];
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam int LO = g * DIGIT_W;

    bcd_digit u_dig (
      .clk (clk),
      .rst (rst),
      .en  (digit_en[g]),
      .clr (clr_cnt),
      .q   (count[LO +: DIGIT_W]),
      .tc  (tc[g])
    );

    assign cnt_nxt[LO +: DIGIT_W] =
      !digit_en[g] ? count[LO +: DIGIT_W] :
      tc[g]        ? '0 :
                     count[LO +: DIGIT_W] + 1'b1;
  end

  assign tz    = (target == '0);
  assign match = digit_en[0] & (cnt_nxt == target);
  assign roll  = digit_en[DIGITS-1] & tc[DIGITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) state_d = tz ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (stop)       state_d = ST_PAUSE;
          else if (match) state_d = ST_DONE;
        end
        ST_PAUSE: begin
          if (stop)       state_d = ST_IDLE;
          else if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A (re)start from IDLE/DONE always reloads zero.
  always_comb begin
    start_ok = start & ~stop & ~clear
             & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    clr_cnt  = clear | start_ok;
    done_d   = match | (start_ok & tz);
    wrap_d   = roll;
  end

  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Scoreboard bench for decade_timer_ctrl: a decimal reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_decade_timer_ctrl;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10000;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] count;
  logic [D-1:0] digit_en;
  logic         running, done, wrap;

  always #5 clk = ~clk;

  decade_timer_ctrl #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .target   (target),
    .count    (count),
    .digit_en (digit_en),
    .running  (running),
    .done     (done),
    .wrap     (wrap)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         run;
    logic         dn;
    logic         wr;
    logic [D-1:0] en;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_st  = S_IDLE;
  int   m_cnt = 0;
  bit   m_run = 1'b0;
  bit   m_dn  = 1'b0;
  bit   m_wr  = 1'b0;
  logic [W-1:0] cur_tg = '0;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of a target, or -1 if any digit is not 0..9.
  function automatic int tg_val(input logic [W-1:0] t);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) begin
      if (t[i*4 +: 4] > 4'd9) return -1;
      v = v * 10 + int'(t[i*4 +: 4]);
    end
    return v;
  endfunction

  task automatic cycle(input bit t, input bit s, input bit p,
                       input bit c, input bit r);
    exp_t e;
    bit   inc;
    bit   nd, nw;
    int   tv;
    @(posedge clk);
    #1;
    tick   = t;
    start  = s;
    stop   = p;
    clear  = c;
    rst    = r;
    target = cur_tg;
    tv     = tg_val(cur_tg);
    e.cnt  = to_bcd(m_cnt);
    e.run  = m_run;
    e.dn   = m_dn;
    e.wr   = m_wr;
    inc    = t && (m_st == S_RUN) && !p && !c && !r;
    e.en   = '0;
    for (int i = 0; i < D; i++)
      if (inc && (m_cnt % p10(i)) == p10(i) - 1)
        e.en[i] = 1'b1;
    sb.push_back(e);
    nd = 1'b0;
    nw = 1'b0;
    if (r || c) begin
      m_st  = S_IDLE;
      m_cnt = 0;
    end else if (m_st == S_IDLE || m_st == S_DONE) begin
      if (s && !p) begin
        m_cnt = 0;
        if (tv == 0) begin
          m_st = S_DONE;
          nd   = 1'b1;
        end else begin
          m_st = S_RUN;
        end
      end
    end else if (m_st == S_RUN) begin
      if (p) begin
        m_st = S_PAUSE;
      end else if (t) begin
        nw    = (m_cnt == MOD - 1);
        m_cnt = (m_cnt + 1) % MOD;
        if (tv == m_cnt) begin
          m_st = S_DONE;
          nd   = 1'b1;
        end
      end
    end else begin
      if (p)      m_st = S_IDLE;
      else if (s) m_st = S_RUN;
    end
    m_run = (m_st == S_RUN);
    m_dn  = nd;
    m_wr  = nw;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  initial begin : mon
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {count, running, done, wrap, digit_en};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL sb t=%0t got cnt=%h run=%b done=%b wrap=%b en=%b required cnt=%h run=%b done=%b wrap=%b en=%b",
                   $time, a.cnt, a.run, a.dn, a.wr, a.en,
                   e.cnt, e.run, e.dn, e.wr, e.en);
        end
      end
    end
  end

  function automatic logic [W-1:0] pick_tg();
    int r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return 16'h00A3;
    return to_bcd($urandom_range(1, 40));
  endfunction

  initial begin : drv
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    chk("reset_out", {count, running, done, wrap, digit_en}, '0);

    cur_tg = 16'h0012;
    cycle(0, 1, 0, 0, 0);
    ticks(12);
    idle(1);
    chk("t1_done", {count, running, done}, {16'h0012, 2'b01});
    idle(1);
    chk("t1_hold", {count, running, done}, {16'h0012, 2'b00});

    cur_tg = 16'h0A00;
    cycle(0, 1, 0, 0, 0);
    ticks(99);
    cycle(1, 0, 0, 0, 0);
    #1;
    chk("t2_en", 32'(digit_en), 32'h7);
    idle(1);
    chk("t2_cnt", 32'(count), 32'h0100);

    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    ticks(42);
    cycle(1, 1, 0, 1, 0);
    idle(1);
    chk("t5_clr", {count, running, done, wrap}, '0);
    cycle(0, 1, 0, 0, 0);
    ticks(5);
    cycle(1, 0, 0, 0, 1);
    idle(1);
    chk("t5_rst", {count, running, done, wrap}, '0);

    cycle(0, 1, 0, 0, 0);
    ticks(5);
    cycle(1, 0, 1, 0, 0);
    ticks(3);
    cycle(1, 1, 0, 0, 0);
    ticks(2);
    idle(1);
    chk("t4_cnt", {count, running}, {16'h0007, 1'b1});

    cycle(0, 0, 0, 1, 0);
    cur_tg = '0;
    cycle(0, 1, 0, 0, 0);
    idle(1);
    chk("t6_done", {count, running, done}, {16'h0000, 2'b01});

    cur_tg = 16'h000A;
    cycle(0, 1, 0, 0, 0);
    ticks(9999);
    cycle(1, 0, 0, 0, 0);
    idle(1);
    chk("t3_wrap", {count, running, wrap}, {16'h0000, 2'b11});
    ticks(3);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 3) cur_tg = pick_tg();
      cycle($urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 1);
    end
    idle(2);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
